// File: rtl/mem_cmd_sequencer_if.sv
// Command port and memory bus bundle for mem_cmd_sequencer.
// master = host issuing commands; slave = the sequencer driving the memory bus.
interface mem_cmd_sequencer_if #(
    parameter int DATA_W = 9,
    parameter int ADDR_W = 3
);
    logic              CMD_VALID;
    logic              CMD_READY;
    logic              CMD_WR;
    logic [ADDR_W-1:0] CMD_ADDR;
    logic [ADDR_W-1:0] CMD_ADDR2;
    logic [DATA_W-1:0] CMD_DATA;
    logic              WR;
    logic              RD;
    logic [ADDR_W-1:0] A1;
    logic [ADDR_W-1:0] A2;
    logic [DATA_W-1:0] D_OUT;
    logic              BUSY;
    logic              DONE;

    modport master (
        output CMD_VALID, CMD_WR, CMD_ADDR, CMD_ADDR2, CMD_DATA,
        input  CMD_READY, WR, RD, A1, A2, D_OUT, BUSY, DONE
    );

    modport slave (
        input  CMD_VALID, CMD_WR, CMD_ADDR, CMD_ADDR2, CMD_DATA,
        output CMD_READY, WR, RD, A1, A2, D_OUT, BUSY, DONE
    );
endinterface

// File: rtl/mem_cmd_sequencer.sv
// Initiator for the 9-bit display memory: queues read/write commands in a
// small FIFO and replays each as a SETUP / STROBE / HOLD bus cycle with
// active-low WR/RD strobes. All bus outputs come straight from flops.
module mem_cmd_sequencer #(
    parameter int DATA_W        = 9,
    parameter int ADDR_W        = 3,
    parameter int FIFO_DEPTH    = 4,
    parameter int STROBE_CYCLES = 1
) (
    input  logic                CLK,
    input  logic                RST,
    mem_cmd_sequencer_if.slave  bus
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 1 + 2 * ADDR_W + DATA_W;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    logic [ENTRY_W-1:0] fifo_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0] fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               cur_wr_q, cur_wr_d;
    logic               wr_n_q, wr_n_d;
    logic               rd_n_q, rd_n_d;
    logic               done_q, done_d;
    logic [ADDR_W-1:0]  a1_q, a1_d;
    logic [ADDR_W-1:0]  a2_q, a2_d;
    logic [DATA_W-1:0]  dout_q, dout_d;

    logic               full, empty, cmd_ready, push, pop;
    logic               head_wr;
    logic [ADDR_W-1:0]  head_addr, head_addr2;
    logic [DATA_W-1:0]  head_data;

    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign cmd_ready = ~full & ~RST;
    assign push      = bus.CMD_VALID & cmd_ready;
    assign {head_wr, head_addr, head_addr2, head_data} = fifo_q[rd_ptr_q];

    assign bus.CMD_READY = cmd_ready;
    assign bus.WR        = wr_n_q;
    assign bus.RD        = rd_n_q;
    assign bus.A1        = a1_q;
    assign bus.A2        = a2_q;
    assign bus.D_OUT     = dout_q;
    assign bus.DONE      = done_q;
    assign bus.BUSY      = (state_q != IDLE) | ~empty;

    // Bus-cycle sequencing; the bus registers are reloaded only when a command is popped
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cur_wr_d = cur_wr_q;
        wr_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        done_d   = 1'b0;
        a1_d     = a1_q;
        a2_d     = a2_q;
        dout_d   = dout_q;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = 4'(STROBE_CYCLES - 1);
                wr_n_d  = ~cur_wr_q;
                rd_n_d  = cur_wr_q;
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    done_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_q - 4'd1;
                    wr_n_d = ~cur_wr_q;
                    rd_n_d = cur_wr_q;
                end
            end
            HOLD: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            cur_wr_d = head_wr;
            a1_d     = head_addr;
            if (head_wr) dout_d = head_data;
            else         a2_d   = head_addr2;
        end
    end

    // Command FIFO bookkeeping; simultaneous push and pop leaves occupancy unchanged
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = {bus.CMD_WR, bus.CMD_ADDR, bus.CMD_ADDR2, bus.CMD_DATA};
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control and bus registers with synchronous reset; reset drops everything in flight
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cur_wr_q <= 1'b0;
            wr_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            done_q   <= 1'b0;
            a1_q     <= '0;
            a2_q     <= '0;
            dout_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cur_wr_q <= cur_wr_d;
            wr_n_q   <= wr_n_d;
            rd_n_q   <= rd_n_d;
            done_q   <= done_d;
            a1_q     <= a1_d;
            a2_q     <= a2_d;
            dout_q   <= dout_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage needs no reset: pointers and count define what is valid
    always_ff @(posedge CLK) begin
        fifo_q <= fifo_d;
    end
endmodule

// File: tb/tb_mem_cmd_sequencer.sv
// Bench for mem_cmd_sequencer: a STROBE_CYCLES=1 and a STROBE_CYCLES=3 build
// share one stimulus stream. A transaction-level model predicts each access's
// start cycle from acceptance time and queue spacing; a compare process checks
// every output of both builds each cycle, and directed literals pin the model.
module tb_mem_cmd_sequencer;
    localparam int MAXC  = 4096;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       valid;
    logic       cwr;
    logic [2:0] caddr;
    logic [2:0] caddr2;
    logic [8:0] cdata;

    mem_cmd_sequencer_if #(.DATA_W(9), .ADDR_W(3)) if0 ();
    mem_cmd_sequencer_if #(.DATA_W(9), .ADDR_W(3)) if1 ();

    assign if0.CMD_VALID = valid;
    assign if0.CMD_WR    = cwr;
    assign if0.CMD_ADDR  = caddr;
    assign if0.CMD_ADDR2 = caddr2;
    assign if0.CMD_DATA  = cdata;
    assign if1.CMD_VALID = valid;
    assign if1.CMD_WR    = cwr;
    assign if1.CMD_ADDR  = caddr;
    assign if1.CMD_ADDR2 = caddr2;
    assign if1.CMD_DATA  = cdata;

    mem_cmd_sequencer #(.DATA_W(9), .ADDR_W(3), .FIFO_DEPTH(4), .STROBE_CYCLES(1)) dut0 (
        .CLK(clk), .RST(rst), .bus(if0));
    mem_cmd_sequencer #(.DATA_W(9), .ADDR_W(3), .FIFO_DEPTH(4), .STROBE_CYCLES(3)) dut1 (
        .CLK(clk), .RST(rst), .bus(if1));

    logic [1:0] o_wr, o_rd, o_busy, o_done, o_ready;
    logic [2:0] o_a1 [2];
    logic [2:0] o_a2 [2];
    logic [8:0] o_d  [2];
    assign o_wr    = {if1.WR, if0.WR};
    assign o_rd    = {if1.RD, if0.RD};
    assign o_busy  = {if1.BUSY, if0.BUSY};
    assign o_done  = {if1.DONE, if0.DONE};
    assign o_ready = {if1.CMD_READY, if0.CMD_READY};
    assign o_a1[0] = if0.A1;
    assign o_a1[1] = if1.A1;
    assign o_a2[0] = if0.A2;
    assign o_a2[1] = if1.A2;
    assign o_d[0]  = if0.D_OUT;
    assign o_d[1]  = if1.D_OUT;

    int vectors;
    int miscompares;
    int cyc;
    bit model_on;

    // Model: accepted commands with their SETUP cycle; pops happen at those cycles
    int         n_acc [2];
    int         n_pop [2];
    int         last_st [2];
    bit         m_wr [2][MAXC];
    logic [2:0] m_a  [2][MAXC];
    logic [2:0] m_a2 [2][MAXC];
    logic [8:0] m_d  [2][MAXC];
    int         m_st [2][MAXC];
    logic [2:0] e_a1 [2];
    logic [2:0] e_a2 [2];
    logic [8:0] e_d  [2];

    function automatic int sc(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model update at each rising edge, from the inputs held across that edge
    initial begin
        int st;
        int k;
        cyc = 0;
        model_on = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_acc[i] = 0; n_pop[i] = 0; last_st[i] = -1000;
        end
        forever begin
            @(posedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    n_acc[i] = 0; n_pop[i] = 0; last_st[i] = -1000;
                    e_a1[i] = '0; e_a2[i] = '0; e_d[i] = '0;
                end else begin
                    if (valid && (n_acc[i] - n_pop[i]) < DEPTH && n_acc[i] < MAXC) begin
                        st = cyc + 1;
                        if (last_st[i] + sc(i) + 2 > st) st = last_st[i] + sc(i) + 2;
                        m_wr[i][n_acc[i]] = cwr;
                        m_a[i][n_acc[i]]  = caddr;
                        m_a2[i][n_acc[i]] = caddr2;
                        m_d[i][n_acc[i]]  = cdata;
                        m_st[i][n_acc[i]] = st;
                        last_st[i] = st;
                        n_acc[i]++;
                    end
                    while (n_pop[i] < n_acc[i] && m_st[i][n_pop[i]] <= cyc) begin
                        k = n_pop[i];
                        e_a1[i] = m_a[i][k];
                        if (m_wr[i][k]) e_d[i] = m_d[i][k];
                        else            e_a2[i] = m_a2[i][k];
                        n_pop[i]++;
                    end
                end
            end
            if (rst) model_on = 1'b1;
        end
    end

    // Per-cycle comparison of both builds against the model
    initial begin
        int  ph;
        bit  in_acc;
        bit  stb;
        bit  cw;
        int  occ;
        forever begin
            @(posedge clk);
            #1;
            if (model_on) begin
                for (int i = 0; i < 2; i++) begin
                    in_acc = 1'b0; ph = 0; cw = 1'b0;
                    if (n_pop[i] > 0) begin
                        ph     = cyc - m_st[i][n_pop[i] - 1];
                        in_acc = (ph <= sc(i) + 1);
                        cw     = m_wr[i][n_pop[i] - 1];
                    end
                    stb = in_acc && ph >= 1 && ph <= sc(i);
                    occ = n_acc[i] - n_pop[i];
                    chk($sformatf("dut%0d_WR", i),    int'(o_wr[i]),    int'(!(stb && cw)));
                    chk($sformatf("dut%0d_RD", i),    int'(o_rd[i]),    int'(!(stb && !cw)));
                    chk($sformatf("dut%0d_DONE", i),  int'(o_done[i]),  int'(in_acc && ph == sc(i) + 1));
                    chk($sformatf("dut%0d_BUSY", i),  int'(o_busy[i]),  int'(in_acc || occ > 0));
                    chk($sformatf("dut%0d_READY", i), int'(o_ready[i]), int'(!rst && occ < DEPTH));
                    chk($sformatf("dut%0d_A1", i),    int'(o_a1[i]),    int'(e_a1[i]));
                    chk($sformatf("dut%0d_A2", i),    int'(o_a2[i]),    int'(e_a2[i]));
                    chk($sformatf("dut%0d_DOUT", i),  int'(o_d[i]),     int'(e_d[i]));
                    chk($sformatf("dut%0d_STROBE_EXCL", i), int'(o_wr[i] | o_rd[i]), 1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic cmd(input bit v, input bit w, input int a, input int a2, input int d);
        valid  = v;
        cwr    = w;
        caddr  = 3'(a);
        caddr2 = 3'(a2);
        cdata  = 9'(d);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (o_busy != 2'b00 && k < 200) begin
            tick();
            k++;
        end
        chk("drain_timeout", int'(k < 200), 1);
    endtask

    // Directed scenarios followed by randomized traffic
    initial begin
        int cnt_a;
        int cnt_b;
        int acc;
        int n;
        bit rdy;
        vectors = 0;
        miscompares = 0;

        // Reset held two cycles with a command offered
        rst = 1'b1;
        cmd(1, 1, 7, 7, 9'h1ff);
        tick(); tick();
        chk("rst_WR", int'(if0.WR), 1);
        chk("rst_RD", int'(if0.RD), 1);
        chk("rst_A1", int'(if0.A1), 0);
        chk("rst_A2", int'(if0.A2), 0);
        chk("rst_DOUT", int'(if0.D_OUT), 0);
        chk("rst_BUSY", int'(o_busy), 0);
        chk("rst_READY", int'(o_ready), 0);
        rst = 1'b0;
        cmd(0, 0, 0, 0, 0);
        tick();
        chk("rst_nopush_BUSY", int'(o_busy), 0);
        chk("rst_release_READY", int'(o_ready), 3);

        // Single write, addr 5 data 1
        cmd(1, 1, 5, 0, 9'h001);
        tick();
        cmd(0, 0, 0, 0, 0);
        tick();
        chk("w1_setup_A1", int'(if0.A1), 5);
        chk("w1_setup_DOUT", int'(if0.D_OUT), 1);
        chk("w1_setup_WR", int'(if0.WR), 1);
        tick();
        chk("w1_strobe_WR", int'(if0.WR), 0);
        chk("w1_strobe_RD", int'(if0.RD), 1);
        tick();
        chk("w1_hold_WR", int'(if0.WR), 1);
        chk("w1_hold_DONE", int'(if0.DONE), 1);
        tick();
        chk("w1_idle_DONE", int'(if0.DONE), 0);
        chk("w1_idle_BUSY", int'(if0.BUSY), 0);
        drain();

        // Write then read back-to-back
        cmd(1, 1, 0, 0, 9'h004);
        tick();
        cmd(1, 0, 5, 0, 9'h155);
        tick();
        cmd(0, 0, 0, 0, 0);
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (if0.DONE) cnt_a++;
            if (!if0.RD) begin
                cnt_b++;
                chk("wr_rd_A1", int'(if0.A1), 5);
                chk("wr_rd_A2", int'(if0.A2), 0);
                chk("wr_rd_DOUT", int'(if0.D_OUT), 4);
            end
        end
        chk("wr_rd_done_pulses", cnt_a, 2);
        chk("wr_rd_rd_cycles", cnt_b, 1);
        drain();

        // Valid held: FIFO fills, READY drops, refills as entries pop
        acc = 0; n = 0;
        valid = 1'b1;
        while (acc < 8 && n < 40) begin
            cmd(1, acc[0], acc, 7 - acc, 9'h100 + acc);
            rdy = if0.CMD_READY;
            tick();
            n++;
            if (rdy) acc++;
            if (n == 6) chk("fill_READY_t6", int'(if0.CMD_READY), 0);
            if (n == 7) chk("fill_READY_t7", int'(if0.CMD_READY), 0);
            if (n == 8) chk("fill_READY_t8", int'(if0.CMD_READY), 1);
        end
        chk("fill_ticks_for_8", n, 12);
        cmd(0, 0, 0, 0, 0);
        drain();

        // Reset during a write strobe with two commands queued
        cmd(1, 1, 3, 0, 9'h0aa);
        tick();
        cmd(1, 0, 4, 1, 0);
        tick();
        cmd(1, 1, 6, 0, 9'h055);
        tick();
        chk("rst_mid_WR_low", int'(if0.WR), 0);
        cmd(0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        chk("rst_mid_WR", int'(if0.WR), 1);
        chk("rst_mid_DONE", int'(o_done), 0);
        chk("rst_mid_BUSY", int'(o_busy), 0);
        rst = 1'b0;
        cnt_a = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (o_wr != 2'b11 || o_rd != 2'b11 || o_done != 2'b00) cnt_a++;
        end
        chk("rst_mid_no_activity", cnt_a, 0);

        // Three-cycle strobe build, single read
        cmd(1, 0, 2, 6, 0);
        tick();
        cmd(0, 0, 0, 0, 0);
        tick();
        chk("sc3_setup_RD", int'(if1.RD), 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("sc3_strobe_RD", int'(if1.RD), 0);
            chk("sc3_strobe_A1", int'(if1.A1), 2);
            chk("sc3_strobe_A2", int'(if1.A2), 6);
            chk("sc3_strobe_DONE", int'(if1.DONE), 0);
        end
        tick();
        chk("sc3_hold_RD", int'(if1.RD), 1);
        chk("sc3_hold_DONE", int'(if1.DONE), 1);
        tick();
        chk("sc3_idle_DONE", int'(if1.DONE), 0);
        drain();

        // Randomized traffic with occasional resets
        for (int k = 0; k < 800; k++) begin
            rst = ($urandom_range(0, 79) == 0);
            cmd($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 511));
            tick();
        end
        rst = 1'b0;
        cmd(0, 0, 0, 0, 0);
        drain();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
